// File: rtl/hmmm_ctrl_pkg.sv
// Shared types and encodings for the HMMM multicycle control sequencer.
// Opcode, branch-type and write-source encodings live here so datapath and control agree.
package hmmm_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        WSRC_ALU = 2'b00,
        WSRC_IMM = 2'b01,
        WSRC_MEM = 2'b10
    } wsrc_t;

    localparam logic [3:0] OP_HALT    = 4'b0000;
    localparam logic [3:0] OP_LOADN   = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SUB     = 4'b0011;
    localparam logic [3:0] OP_LOADR   = 4'b0100;
    localparam logic [3:0] OP_STORER  = 4'b0101;
    localparam logic [3:0] OP_NOP     = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL = 4'b0111;
    localparam logic [3:0] OP_JCOND   = 4'b1000;
    localparam logic [3:0] OP_JUMP    = 4'b1100;

    localparam logic [1:0] BR_JEQZN = 2'b00;
    localparam logic [1:0] BR_JNEZN = 2'b01;
    localparam logic [1:0] BR_JGTZN = 2'b10;
    localparam logic [1:0] BR_JLTZN = 2'b11;

    // opcode[2] set means unconditional jump; otherwise tt selects the flag test
    function automatic logic branch_taken(input logic [3:0] op,
                                          input logic       zero,
                                          input logic       neg);
        logic cond;
        case (op[1:0])
            BR_JEQZN: cond = zero;
            BR_JNEZN: cond = ~zero;
            BR_JGTZN: cond = ~neg & ~zero;
            BR_JLTZN: cond = neg;
            default:  cond = 1'b0;
        endcase
        return op[2] | cond;
    endfunction

endpackage

// File: rtl/hmmm_multicycle_ctrl_if.sv
// Control bus between the multicycle sequencer (master) and the datapath/memory side (slave).
interface hmmm_multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       reg_zero;
    logic       reg_neg;
    logic       mem_ack;
    logic       step;
    logic       pc_en;
    logic       pc_src;
    logic       ir_load;
    logic       reg_write;
    logic [1:0] reg_wsrc;
    logic       alu_sub;
    logic       mem_req;
    logic       mem_we;
    logic       halted;
    logic       fault;

    modport master (
        input  opcode, reg_zero, reg_neg, mem_ack, step,
        output pc_en, pc_src, ir_load, reg_write, reg_wsrc, alu_sub,
               mem_req, mem_we, halted, fault
    );

    modport slave (
        output opcode, reg_zero, reg_neg, mem_ack, step,
        input  pc_en, pc_src, ir_load, reg_write, reg_wsrc, alu_sub,
               mem_req, mem_we, halted, fault
    );
endinterface

// File: rtl/hmmm_multicycle_ctrl_mem_timeout_ctr.sv
// Memory handshake watchdog: counts unacknowledged request cycles and flags
// the cycle on which the count reaches TIMEOUT_CYCLES.
module mem_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_expired
);
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    // wait-cycle counter; clear has priority so an ack always restarts the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_count_en) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    // the current unacked cycle is the TIMEOUT_CYCLES-th one
    assign o_expired = i_count_en & (r_count == LAST_COUNT);
endmodule

// File: rtl/hmmm_multicycle_ctrl.sv
// Multicycle control sequencer for the 4-bit HMMM core (FETCH/DECODE/EXEC/MEMACC/WB).
// Optional single-step gating of instruction fetch: define HMMM_SINGLE_STEP_EN.
module hmmm_multicycle_ctrl
    import hmmm_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    hmmm_multicycle_ctrl_if.master bus
);
    state_t r_state;
    logic   w_mem_req;
    logic   w_handshake;
    logic   w_count_en;
    logic   w_expired;
    logic   w_taken;

    logic   w_pc_en, w_pc_src, w_ir_load, w_reg_write, w_alu_sub;
    logic   w_req_out, w_mem_we, w_halted, w_fault;
    wsrc_t  w_wsrc;

`ifdef HMMM_SINGLE_STEP_EN
    logic r_step_pending;

    // one fetch per step pulse; a pulse while one is already pending is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_pending <= 1'b0;
        end else if ((r_state == S_FETCH) && w_handshake) begin
            r_step_pending <= 1'b0;
        end else if (bus.step) begin
            r_step_pending <= 1'b1;
        end else begin
            r_step_pending <= r_step_pending;
        end
    end

    assign w_mem_req = (r_state == S_MEMACC) | ((r_state == S_FETCH) & r_step_pending);
`else
    logic w_unused;
    assign w_unused  = bus.step;
    assign w_mem_req = (r_state == S_MEMACC) | (r_state == S_FETCH);
`endif

    assign w_handshake = w_mem_req & bus.mem_ack;
    assign w_count_en  = w_mem_req & ~bus.mem_ack;
    assign w_taken     = branch_taken(bus.opcode, bus.reg_zero, bus.reg_neg);

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_count_en (w_count_en),
        .i_clear    (~w_count_en),
        .o_expired  (w_expired)
    );

    // instruction sequencing; an ack in the expiry cycle wins over the fault
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_handshake)    r_state <= S_DECODE;
                    else if (w_expired) r_state <= S_FAULT;
                    else                r_state <= S_FETCH;
                end
                S_DECODE: begin
                    case (bus.opcode)
                        OP_HALT:             r_state <= S_HALT;
                        OP_NOP:              r_state <= S_FETCH;
                        OP_LOADN:            r_state <= S_WB;
                        OP_ADD, OP_SUB:      r_state <= S_EXEC;
                        OP_LOADR, OP_STORER: r_state <= S_MEMACC;
                        OP_ILLEGAL:          r_state <= S_FAULT;
                        default:             r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    if (bus.opcode[3]) r_state <= S_FETCH;
                    else               r_state <= S_WB;
                end
                S_MEMACC: begin
                    if (w_handshake)    r_state <= (bus.opcode == OP_STORER) ? S_FETCH : S_WB;
                    else if (w_expired) r_state <= S_FAULT;
                    else                r_state <= S_MEMACC;
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FAULT;
            endcase
        end
    end

    // strobes decoded from state; forced low while reset is high so a request drops at once
    always_comb begin
        w_pc_en     = 1'b0;
        w_pc_src    = 1'b0;
        w_ir_load   = 1'b0;
        w_reg_write = 1'b0;
        w_wsrc      = WSRC_ALU;
        w_alu_sub   = 1'b0;
        w_req_out   = 1'b0;
        w_mem_we    = 1'b0;
        w_halted    = 1'b0;
        w_fault     = 1'b0;
        if (reset) begin
            w_req_out = 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    w_req_out = w_mem_req;
                    w_ir_load = w_handshake;
                    w_pc_en   = w_handshake;
                end
                S_EXEC: begin
                    if (bus.opcode[3]) begin
                        w_pc_en  = w_taken;
                        w_pc_src = w_taken;
                    end else begin
                        w_alu_sub = (bus.opcode == OP_SUB);
                    end
                end
                S_MEMACC: begin
                    w_req_out = 1'b1;
                    w_mem_we  = (bus.opcode == OP_STORER);
                end
                S_WB: begin
                    w_reg_write = 1'b1;
                    w_alu_sub   = (bus.opcode == OP_SUB);
                    case (bus.opcode)
                        OP_LOADN: w_wsrc = WSRC_IMM;
                        OP_LOADR: w_wsrc = WSRC_MEM;
                        default:  w_wsrc = WSRC_ALU;
                    endcase
                end
                S_HALT:  w_halted = 1'b1;
                S_FAULT: w_fault  = 1'b1;
                default: w_fault  = 1'b0;
            endcase
        end
    end

    assign bus.pc_en     = w_pc_en;
    assign bus.pc_src    = w_pc_src;
    assign bus.ir_load   = w_ir_load;
    assign bus.reg_write = w_reg_write;
    assign bus.reg_wsrc  = w_wsrc;
    assign bus.alu_sub   = w_alu_sub;
    assign bus.mem_req   = w_req_out;
    assign bus.mem_we    = w_mem_we;
    assign bus.halted    = w_halted;
    assign bus.fault     = w_fault;
endmodule

// File: tb/tb_hmmm_multicycle_ctrl.sv
// Directed self-checking bench for hmmm_multicycle_ctrl (default and 4-cycle timeout instances).
module tb_hmmm_multicycle_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    hmmm_multicycle_ctrl_if a();
    hmmm_multicycle_ctrl_if b();

    hmmm_multicycle_ctrl #(.TIMEOUT_CYCLES(15)) dut_a (.clk(clk), .reset(reset), .bus(a));
    hmmm_multicycle_ctrl #(.TIMEOUT_CYCLES(4))  dut_b (.clk(clk), .reset(reset), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, pc_src, ir_load, reg_write, reg_wsrc[1:0], alu_sub, mem_req, mem_we, halted, fault}
    localparam logic [10:0] V_IDLE   = 11'b0_0_0_0_00_0_0_0_0_0;
    localparam logic [10:0] V_FACK   = 11'b1_0_1_0_00_0_1_0_0_0;
    localparam logic [10:0] V_REQ    = 11'b0_0_0_0_00_0_1_0_0_0;
    localparam logic [10:0] V_SUBEX  = 11'b0_0_0_0_00_1_0_0_0_0;
    localparam logic [10:0] V_WBALU  = 11'b0_0_0_1_00_0_0_0_0_0;
    localparam logic [10:0] V_WBSUB  = 11'b0_0_0_1_00_1_0_0_0_0;
    localparam logic [10:0] V_WBIMM  = 11'b0_0_0_1_01_0_0_0_0_0;
    localparam logic [10:0] V_WBMEM  = 11'b0_0_0_1_10_0_0_0_0_0;
    localparam logic [10:0] V_TAKEN  = 11'b1_1_0_0_00_0_0_0_0_0;
    localparam logic [10:0] V_STORE  = 11'b0_0_0_0_00_0_1_1_0_0;
    localparam logic [10:0] V_HALT   = 11'b0_0_0_0_00_0_0_0_1_0;
    localparam logic [10:0] V_FAULT  = 11'b0_0_0_0_00_0_0_0_0_1;

    function automatic logic [10:0] outs_a();
        return {a.pc_en, a.pc_src, a.ir_load, a.reg_write, a.reg_wsrc,
                a.alu_sub, a.mem_req, a.mem_we, a.halted, a.fault};
    endfunction

    function automatic logic [10:0] outs_b();
        return {b.pc_en, b.pc_src, b.ir_load, b.reg_write, b.reg_wsrc,
                b.alu_sub, b.mem_req, b.mem_we, b.halted, b.fault};
    endfunction

`ifndef HMMM_SINGLE_STEP_EN
    task automatic test_reset();
        a.opcode = 4'b0010; a.mem_ack = 1'b0; b.mem_ack = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if ((outs_a() !== V_IDLE) || (outs_b() !== V_IDLE)) begin
                n_errors++;
                $display("FAIL reset cycle %0d: got a=%b b=%b expected %b", i, outs_a(), outs_b(), V_IDLE);
            end
        end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++;
        if (outs_a() !== V_REQ) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected %b", outs_a(), V_REQ);
        end
    endtask

    task automatic test_alu();
        logic [10:0] exp [0:3];
        for (int k = 0; k < 2; k++) begin
            exp[0] = V_FACK; exp[1] = V_IDLE;
            exp[2] = (k == 0) ? V_IDLE  : V_SUBEX;
            exp[3] = (k == 0) ? V_WBALU : V_WBSUB;
            @(negedge clk);
            a.opcode = (k == 0) ? 4'b0010 : 4'b0011; a.mem_ack = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                #1; n_checks++;
                if (outs_a() !== exp[i]) begin
                    n_errors++;
                    $display("FAIL alu op%0d cycle %0d: got %b expected %b", k, i, outs_a(), exp[i]);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0]  ops   [0:4] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100};
        logic        zeros [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        negs  [0:4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [10:0] exex  [0:4] = '{V_TAKEN, V_TAKEN, V_IDLE, V_IDLE, V_TAKEN};
        logic [10:0] exp;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a.opcode = ops[k]; a.reg_zero = zeros[k]; a.reg_neg = negs[k]; a.mem_ack = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (i > 0) @(negedge clk);
                #1; n_checks++;
                exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : exex[k]);
                if (outs_a() !== exp) begin
                    n_errors++;
                    $display("FAIL branch op=%b cycle %0d: got %b expected %b", ops[k], i, outs_a(), exp);
                end
            end
        end
        a.reg_zero = 1'b0; a.reg_neg = 1'b0;
    endtask

    task automatic test_loadr_storer();
        logic [10:0] exp;
        @(negedge clk);
        a.opcode = 4'b0100; a.mem_ack = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            a.mem_ack = (i == 0) || (i >= 7);
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : ((i == 8) ? V_WBMEM : V_REQ));
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL loadr cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
        @(negedge clk);
        a.opcode = 4'b0101; a.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : V_STORE);
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL storer cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
    endtask

    task automatic test_nop_loadn();
        logic [10:0] exp;
        @(negedge clk);
        a.opcode = 4'b0110; a.mem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : V_IDLE;
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL nop cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
        @(negedge clk);
        a.opcode = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : V_WBIMM);
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL loadn cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
    endtask

    task automatic test_halt_illegal();
        logic [10:0] exp;
        @(negedge clk);
        a.opcode = 4'b0000; a.mem_ack = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i > 0) @(negedge clk);
            a.mem_ack = i[0];
            if (i == 0) a.mem_ack = 1'b1;
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : V_HALT);
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL halt cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
        @(negedge clk); reset = 1'b1; #1;
        n_checks++;
        if (outs_a() !== V_IDLE) begin
            n_errors++;
            $display("FAIL halt_reset: got %b expected %b", outs_a(), V_IDLE);
        end
        @(negedge clk); reset = 1'b0; a.opcode = 4'b0111; a.mem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : V_FAULT);
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL illegal cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
    endtask

    task automatic test_reset_mid_memacc();
        logic [10:0] exp;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; a.opcode = 4'b0100; a.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) a.mem_ack = 1'b0;
            #1; n_checks++;
            exp = (i == 0) ? V_FACK : ((i == 1) ? V_IDLE : V_REQ);
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL memacc_pre cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
        #1; reset = 1'b1; #1;
        n_checks++;
        if (a.mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL memacc_reset_req: got %b expected %b", a.mem_req, 1'b0);
        end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++;
        if (outs_a() !== V_REQ) begin
            n_errors++;
            $display("FAIL memacc_release: got %b expected %b", outs_a(), V_REQ);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] exp;
        b.opcode = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); reset = 1'b1; b.mem_ack = 1'b0;
            @(negedge clk); reset = 1'b0;
            for (int i = 1; i <= 7; i++) begin
                if (i > 1) @(negedge clk);
                b.mem_ack = (k == 1) && (i == 4);
                #1; n_checks++;
                if (k == 0) exp = (i <= 4) ? V_REQ : V_FAULT;
                else        exp = (i == 4) ? V_FACK : ((i == 5) ? V_IDLE : V_REQ);
                if (outs_b() !== exp) begin
                    n_errors++;
                    $display("FAIL timeout run%0d cycle %0d: got %b expected %b", k, i, outs_b(), exp);
                end
            end
        end
    endtask
`else
    task automatic test_single_step();
        logic [10:0] exp;
        a.opcode = 4'b0010; a.mem_ack = 1'b1; a.step = 1'b0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            a.step = (i == 10) || (i == 11);
            #1; n_checks++;
            if (i == 11)      exp = V_FACK;
            else if (i == 14) exp = V_WBALU;
            else              exp = V_IDLE;
            if (outs_a() !== exp) begin
                n_errors++;
                $display("FAIL step cycle %0d: got %b expected %b", i, outs_a(), exp);
            end
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        a.opcode = 4'b0000; a.reg_zero = 1'b0; a.reg_neg = 1'b0; a.mem_ack = 1'b0; a.step = 1'b0;
        b.opcode = 4'b0110; b.reg_zero = 1'b0; b.reg_neg = 1'b0; b.mem_ack = 1'b0; b.step = 1'b0;
`ifdef HMMM_SINGLE_STEP_EN
        test_single_step();
`else
        test_reset();
        test_alu();
        test_branch();
        test_loadr_storer();
        test_nop_loadn();
        test_halt_illegal();
        test_reset_mid_memacc();
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
